// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, flush handling
// and a saturating count of inserted bubbles.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [9:0]        ID_CTRL,
  input  logic [DATA_W-1:0] ID_PC4,
  input  logic [DATA_W-1:0] ID_RD1,
  input  logic [DATA_W-1:0] ID_RD2,
  input  logic [DATA_W-1:0] ID_IMM,
  input  logic [REG_AW-1:0] ID_RS,
  input  logic [REG_AW-1:0] ID_RT,
  input  logic [REG_AW-1:0] ID_RD,
  input  logic              ID_USES_RT,
  input  logic              FLUSH,
  output logic [9:0]        EX_CTRL,
  output logic [DATA_W-1:0] EX_PC4,
  output logic [DATA_W-1:0] EX_RD1,
  output logic [DATA_W-1:0] EX_RD2,
  output logic [DATA_W-1:0] EX_IMM,
  output logic [REG_AW-1:0] EX_RS,
  output logic [REG_AW-1:0] EX_RT,
  output logic [REG_AW-1:0] EX_RD,
  output logic              EX_VALID,
  output logic              STALL,
  output logic [CNT_W-1:0]  BUBBLE_CNT
);

  localparam int MEM_READ_BIT = 6;

  logic ex_is_load;
  logic rs_match;
  logic rt_match;
  logic insert_bubble;

  // A load in EX whose destination is a live source of the ID instruction
  // must hold ID for one cycle; $zero is never a real dependency.
  assign ex_is_load    = EX_VALID & EX_CTRL[MEM_READ_BIT] & (EX_RT != '0);
  assign rs_match      = (EX_RT == ID_RS);
  assign rt_match      = ID_USES_RT & (EX_RT == ID_RT);
  assign STALL         = ex_is_load & (rs_match | rt_match);
  assign insert_bubble = FLUSH | STALL;

  // Data and index fields simply hold during a bubble; only the cleared
  // control bundle and EX_VALID matter downstream.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      EX_CTRL    <= '0;
      EX_PC4     <= '0;
      EX_RD1     <= '0;
      EX_RD2     <= '0;
      EX_IMM     <= '0;
      EX_RS      <= '0;
      EX_RT      <= '0;
      EX_RD      <= '0;
      EX_VALID   <= 1'b0;
      BUBBLE_CNT <= '0;
    end else if (insert_bubble) begin
      EX_CTRL  <= '0;
      EX_VALID <= 1'b0;
      if (BUBBLE_CNT != '1) begin
        BUBBLE_CNT <= BUBBLE_CNT + CNT_W'(1);
      end
    end else begin
      EX_CTRL  <= ID_CTRL;
      EX_PC4   <= ID_PC4;
      EX_RD1   <= ID_RD1;
      EX_RD2   <= ID_RD2;
      EX_IMM   <= ID_IMM;
      EX_RS    <= ID_RS;
      EX_RT    <= ID_RT;
      EX_RD    <= ID_RD;
      EX_VALID <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver queues the expected EX state
// and STALL for each cycle, a negedge monitor pops and compares.
module tb_id_ex_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = 2;

  localparam logic [9:0] RTYPE = 10'b1000010001;
  localparam logic [9:0] LW    = 10'b0001100011;
  localparam logic [9:0] SW    = 10'b0000000110;
  localparam logic [9:0] ADDI  = 10'b0000000011;

  logic              CLK;
  logic              RST_N;
  logic [9:0]        ID_CTRL;
  logic [DATA_W-1:0] ID_PC4, ID_RD1, ID_RD2, ID_IMM;
  logic [REG_AW-1:0] ID_RS, ID_RT, ID_RD;
  logic              ID_USES_RT, FLUSH;
  logic [9:0]        EX_CTRL;
  logic [DATA_W-1:0] EX_PC4, EX_RD1, EX_RD2, EX_IMM;
  logic [REG_AW-1:0] EX_RS, EX_RT, EX_RD;
  logic              EX_VALID, STALL;
  logic [CNT_W-1:0]  BUBBLE_CNT;

  typedef struct {
    logic        stall;
    logic [9:0]  ctrl;
    logic        valid;
    logic [31:0] pc4, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic [1:0]  cnt;
  } exp_t;

  exp_t expQ[$];
  exp_t mon;
  exp_t model;

  int compared   = 0;
  int mismatched = 0;

  id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .ID_CTRL(ID_CTRL), .ID_PC4(ID_PC4), .ID_RD1(ID_RD1), .ID_RD2(ID_RD2),
    .ID_IMM(ID_IMM), .ID_RS(ID_RS), .ID_RT(ID_RT), .ID_RD(ID_RD),
    .ID_USES_RT(ID_USES_RT), .FLUSH(FLUSH),
    .EX_CTRL(EX_CTRL), .EX_PC4(EX_PC4), .EX_RD1(EX_RD1), .EX_RD2(EX_RD2),
    .EX_IMM(EX_IMM), .EX_RS(EX_RS), .EX_RT(EX_RT), .EX_RD(EX_RD),
    .EX_VALID(EX_VALID), .STALL(STALL), .BUBBLE_CNT(BUBBLE_CNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h",
               name, $time, actual, expected);
    end
  endtask

  task automatic modelReset();
    model.stall = 1'b0;
    model.ctrl  = '0;
    model.valid = 1'b0;
    model.pc4   = '0;
    model.rd1   = '0;
    model.rd2   = '0;
    model.imm   = '0;
    model.rs    = '0;
    model.rt    = '0;
    model.rd    = '0;
    model.cnt   = '0;
  endtask

  // Drive one ID instruction and queue what the monitor should see this cycle.
  task automatic driveAndPush(input logic [9:0] ctrl, input logic [31:0] pc4,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] imm, input logic [4:0] rs,
                              input logic [4:0] rt, input logic [4:0] rd,
                              input logic usesRt, input logic flush,
                              input logic expStall);
    exp_t e;
    ID_CTRL = ctrl; ID_PC4 = pc4; ID_RD1 = rd1; ID_RD2 = rd2; ID_IMM = imm;
    ID_RS = rs; ID_RT = rt; ID_RD = rd; ID_USES_RT = usesRt; FLUSH = flush;
    e = model;
    e.stall = expStall;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic [9:0] ctrl, input logic [31:0] pc4,
                               input logic [31:0] rd1, input logic [31:0] rd2,
                               input logic [31:0] imm, input logic [4:0] rs,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic usesRt, input logic flush,
                               input logic expStall);
    driveAndPush(ctrl, pc4, rd1, rd2, imm, rs, rt, rd, usesRt, flush, expStall);
    if (flush || expStall) begin
      model.ctrl  = '0;
      model.valid = 1'b0;
      if (model.cnt != 2'd3) model.cnt = model.cnt + 2'd1;
    end else begin
      model.ctrl = ctrl; model.pc4 = pc4; model.rd1 = rd1; model.rd2 = rd2;
      model.imm  = imm;  model.rs  = rs;  model.rt  = rt;  model.rd  = rd;
      model.valid = 1'b1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " EX_CTRL"},    32'(EX_CTRL),    32'd0);
    checkOutput({tag, " EX_VALID"},   32'(EX_VALID),   32'd0);
    checkOutput({tag, " BUBBLE_CNT"}, 32'(BUBBLE_CNT), 32'd0);
    checkOutput({tag, " STALL"},      32'(STALL),      32'd0);
    checkOutput({tag, " EX_PC4"},     EX_PC4,          32'd0);
    checkOutput({tag, " EX_RD1"},     EX_RD1,          32'd0);
    checkOutput({tag, " EX_RD2"},     EX_RD2,          32'd0);
    checkOutput({tag, " EX_IMM"},     EX_IMM,          32'd0);
    checkOutput({tag, " EX_RS"},      32'(EX_RS),      32'd0);
    checkOutput({tag, " EX_RT"},      32'(EX_RT),      32'd0);
    checkOutput({tag, " EX_RD"},      32'(EX_RD),      32'd0);
  endtask

  // Monitor: every cycle with a queued expectation is checked mid-cycle.
  always begin
    @(negedge CLK);
    if (expQ.size() > 0) begin
      mon = expQ.pop_front();
      checkOutput("STALL",      32'(STALL),      32'(mon.stall));
      checkOutput("EX_CTRL",    32'(EX_CTRL),    32'(mon.ctrl));
      checkOutput("EX_VALID",   32'(EX_VALID),   32'(mon.valid));
      checkOutput("BUBBLE_CNT", 32'(BUBBLE_CNT), 32'(mon.cnt));
      if (mon.valid) begin
        checkOutput("EX_PC4", EX_PC4, mon.pc4);
        checkOutput("EX_RD1", EX_RD1, mon.rd1);
        checkOutput("EX_RD2", EX_RD2, mon.rd2);
        checkOutput("EX_IMM", EX_IMM, mon.imm);
        checkOutput("EX_RS",  32'(EX_RS), 32'(mon.rs));
        checkOutput("EX_RT",  32'(EX_RT), 32'(mon.rt));
        checkOutput("EX_RD",  32'(EX_RD), 32'(mon.rd));
      end
    end
  end

  initial begin
    RST_N = 1'b0;
    ID_CTRL = '0; ID_PC4 = '0; ID_RD1 = '0; ID_RD2 = '0; ID_IMM = '0;
    ID_RS = '0; ID_RT = '0; ID_RD = '0; ID_USES_RT = 1'b0; FLUSH = 1'b0;
    modelReset();
    #2;
    checkAllZero("reset");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    $display("[TB] reset released, starting directed vectors");

    //             ctrl   pc4 rd1  rd2 imm rs  rt  rd usesRt flush stall
    applyStimulus(RTYPE,  4,   5,   7,  0,  1,  2,  3, 1, 0, 0);
    applyStimulus(LW,     8, 100,   0,  4,  4,  8,  0, 0, 0, 0);
    applyStimulus(RTYPE, 12,  11,  22,  0,  8,  2,  5, 1, 0, 1);
    applyStimulus(RTYPE, 12,  11,  22,  0,  8,  2,  5, 1, 0, 0);
    applyStimulus(LW,    16, 200,   0,  8,  1,  9,  0, 0, 0, 0);
    applyStimulus(SW,    20,  33,  44, 12,  3,  9,  0, 1, 0, 1);
    applyStimulus(LW,    24, 200,   0,  8,  1,  9,  0, 0, 0, 0);
    applyStimulus(ADDI,  28,  66,  77, 16,  5,  9,  9, 0, 0, 0);
    applyStimulus(LW,    32,   1,   0, 20,  2,  0,  0, 0, 0, 0);
    applyStimulus(RTYPE, 36,   0,   0,  0,  0,  0,  6, 1, 0, 0);
    applyStimulus(LW,    40, 300,   0, 24,  2,  8,  0, 0, 0, 0);
    applyStimulus(RTYPE, 44,   8,   9,  0,  8,  1,  7, 1, 1, 1);
    applyStimulus(RTYPE, 48,  10,  11,  0, 10,  1,  7, 1, 0, 0);
    applyStimulus(LW,    52, 400,   0, 28, 10, 11,  0, 0, 0, 0);
    applyStimulus(LW,    56, 500,   0, 32, 11, 12,  0, 0, 0, 1);
    applyStimulus(LW,    56, 500,   0, 32, 11, 12,  0, 0, 0, 0);
    applyStimulus(RTYPE, 60,   1,   2,  0, 12,  3,  4, 1, 0, 1);
    applyStimulus(RTYPE, 60,   1,   2,  0, 12,  3,  4, 1, 0, 0);
    applyStimulus(RTYPE, 64,   3,   4,  0,  1,  2,  3, 1, 1, 0);
    applyStimulus(RTYPE, 68,   5,   6,  0,  2,  3,  4, 1, 0, 0);
    applyStimulus(LW,    72, 600,   0, 36,  1, 13,  0, 0, 0, 0);

    // Hazard is live when reset drops between edges.
    driveAndPush(RTYPE, 76, 55, 66, 0, 13, 14, 15, 1, 0, 1);
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    checkAllZero("mid-stall reset");
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    modelReset();
    applyStimulus(RTYPE, 76, 55, 66, 0, 13, 14, 15, 1, 0, 0);
    applyStimulus(ADDI,  80,  1,  1, 4,  0,  0,  0, 0, 0, 0);

    for (int i = 0; i < 10 && expQ.size() > 0; i++) @(negedge CLK);
    #1;
    checkOutput("queue drained", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
